// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: round-robin sharing of one CPOL=0, MSB-first SPI bus between NREQ requesters.
// Receive path (miso -> rd_data) is compiled in only with `define SPI_SCHED_READBACK_EN.
module spi_bus_scheduler #(
  parameter int NREQ       = 4,
  parameter int NSLAVE     = 4,
  parameter int DIV        = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [2*NREQ-1:0]   req_ss,
  input  logic [6*NREQ-1:0]   req_len,
  input  logic [32*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]     done,
  output logic [31:0]         rd_data,
  output logic                busy,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [NSLAVE-1:0]   sen_n
);
  localparam int RW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (DIV > GAP_CYCLES) ? DIV : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [5:0]        bits_left_reg, bits_left_next;
  logic [31:0]       data_reg, data_next;
  logic [RW-1:0]     winner_reg, winner_next;
  logic [RW-1:0]     rr_reg, rr_next;
  logic [NREQ-1:0]   done_reg, done_next;
  logic              busy_reg, busy_next;
  logic              sclk_reg, sclk_next;
  logic              mosi_reg, mosi_next;
  logic [NSLAVE-1:0] sen_n_reg, sen_n_next;
`ifdef SPI_SCHED_READBACK_EN
  logic [31:0]       rx_reg, rx_next;
  logic [31:0]       rd_reg, rd_next;
`endif

  logic [1:0]  ss_arr   [NREQ];
  logic [5:0]  len_arr  [NREQ];
  logic [31:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign ss_arr[gi]   = req_ss[2*gi +: 2];
      assign len_arr[gi]  = req_len[6*gi +: 6];
      assign data_arr[gi] = req_data[32*gi +: 32];
    end
  endgenerate

  // First valid requester at or above the rr pointer, wrapping.
  logic          grant_any;
  logic [RW-1:0] grant_idx;
  logic [RW-1:0] scan_idx;
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = RW'((int'(rr_reg) + k) % NREQ);
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  logic [1:0]  sel_ss;
  logic [5:0]  sel_len;
  logic [31:0] sel_data;
  logic        sel_null;
  logic        start;
  logic [5:0]  nb;
  assign sel_ss   = ss_arr[grant_idx];
  assign sel_len  = (len_arr[grant_idx] > 6'd32) ? 6'd32 : len_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];
  assign sel_null = (sel_len == 6'd0) || (int'(sel_ss) >= NSLAVE);
  // Arbitration also runs on the final GAP cycle so back-to-back transfers see exactly GAP_CYCLES idle cycles.
  assign start    = grant_any && ((state_reg == IDLE) || ((state_reg == GAP) && (cnt_reg == GAP_LAST)));
  assign nb       = bits_left_reg - 6'd1;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bits_left_next = bits_left_reg;
    data_next      = data_reg;
    winner_next    = winner_reg;
    rr_next        = rr_reg;
    done_next      = '0;
    busy_next      = busy_reg;
    sclk_next      = sclk_reg;
    mosi_next      = mosi_reg;
    sen_n_next     = sen_n_reg;
`ifdef SPI_SCHED_READBACK_EN
    rx_next        = rx_reg;
    rd_next        = rd_reg;
`endif
    case (state_reg)
      SETUP: begin
        if (cnt_reg == DIV_LAST) begin
          state_next = SHIFT_HI;
          cnt_next   = '0;
          sclk_next  = 1'b1;
`ifdef SPI_SCHED_READBACK_EN
          rx_next    = {rx_reg[30:0], miso};
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt_reg == DIV_LAST) begin
          state_next     = SHIFT_LO;
          cnt_next       = '0;
          sclk_next      = 1'b0;
          bits_left_next = nb;
          if (nb != 6'd0) mosi_next = data_reg[5'(nb - 6'd1)];
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (bits_left_reg == 6'd0) begin
            state_next             = GAP;
            sen_n_next             = '1;
            mosi_next              = 1'b0;
            done_next[winner_reg]  = 1'b1;
`ifdef SPI_SCHED_READBACK_EN
            rd_next                = rx_reg;
`endif
          end else begin
            state_next = SHIFT_HI;
            sclk_next  = 1'b1;
`ifdef SPI_SCHED_READBACK_EN
            rx_next    = {rx_reg[30:0], miso};
`endif
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase

    if (start) begin
      winner_next    = grant_idx;
      rr_next        = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
      busy_next      = 1'b1;
      cnt_next       = '0;
      data_next      = sel_data;
      bits_left_next = sel_len;
`ifdef SPI_SCHED_READBACK_EN
      rx_next        = '0;
`endif
      if (sel_null) begin
        state_next           = GAP;
        done_next[grant_idx] = 1'b1;
`ifdef SPI_SCHED_READBACK_EN
        rd_next              = '0;
`endif
      end else begin
        state_next = SETUP;
        sen_n_next = ~(NSLAVE'(1) << sel_ss);
        sclk_next  = 1'b0;
        mosi_next  = sel_data[5'(sel_len - 6'd1)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bits_left_reg <= '0;
      data_reg      <= '0;
      winner_reg    <= '0;
      rr_reg        <= '0;
      done_reg      <= '0;
      busy_reg      <= 1'b0;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      sen_n_reg     <= '1;
`ifdef SPI_SCHED_READBACK_EN
      rx_reg        <= '0;
      rd_reg        <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bits_left_reg <= bits_left_next;
      data_reg      <= data_next;
      winner_reg    <= winner_next;
      rr_reg        <= rr_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      sclk_reg      <= sclk_next;
      mosi_reg      <= mosi_next;
      sen_n_reg     <= sen_n_next;
`ifdef SPI_SCHED_READBACK_EN
      rx_reg        <= rx_next;
      rd_reg        <= rd_next;
`endif
    end
  end

  assign done  = done_reg;
  assign busy  = busy_reg;
  assign sclk  = sclk_reg;
  assign mosi  = mosi_reg;
  assign sen_n = sen_n_reg;
`ifdef SPI_SCHED_READBACK_EN
  assign rd_data = rd_reg;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rd_data     = '0;
`endif
endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Bench for spi_bus_scheduler: directed table, arbitration/reset/gap sequences, then random traffic vs a queue-level model.
module tb_spi_bus_scheduler;
  localparam int NREQ = 4, NSLAVE = 4, DIV = 2, GAP_CYCLES = 2;
`ifdef SPI_SCHED_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [7:0]   req_ss;
  logic [23:0]  req_len;
  logic [127:0] req_data;
  logic [3:0]   done;
  logic [31:0]  rd_data;
  logic         busy, sclk, mosi, miso;
  logic [3:0]   sen_n;

  always #5 clk = ~clk;

  spi_bus_scheduler #(.NREQ(NREQ), .NSLAVE(NSLAVE), .DIV(DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ss(req_ss), .req_len(req_len),
    .req_data(req_data), .done(done), .rd_data(rd_data), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .sen_n(sen_n)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  done;
    int          low_cnt;
    int          ss_low;
    int          rises;
    logic [31:0] bits;
    logic [31:0] rd;
    logic        busy;
  } rec_t;

  typedef struct {
    int          req;
    int          ss;
    int          len;
    logic [31:0] data;
    logic [31:0] miso;
    bit          drop_mid;
    int          exp_slave;
    int          exp_low;
    logic [31:0] exp_bits;
    logic [31:0] exp_rd_rb;
  } vec_t;

  rec_t        rec_q[$];
  logic [31:0] miso_word;
  int          hi_run, last_gap;
  bit          seen_low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bus observer plus a slave that presents miso_word MSB-first, one bit per sclk rise.
  initial begin : monitor
    int low_cnt, ss_low, rises;
    logic [31:0] bits;
    logic prev_sclk;
    low_cnt = 0; ss_low = -1; rises = 0; bits = '0; prev_sclk = 1'b0;
    hi_run = 0; last_gap = -1; seen_low = 0; miso = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_cnt = 0; ss_low = -1; rises = 0; bits = '0; prev_sclk = 1'b0;
        hi_run = 0; seen_low = 0; miso = 1'b0;
      end else begin
        chk("one_enable", 32'($countones(~sen_n) <= 1), 32'd1);
        if (sen_n != 4'hF) begin
          if (seen_low && low_cnt == 0) last_gap = hi_run;
          hi_run = 0;
          seen_low = 1;
          low_cnt++;
          for (int s = 0; s < 4; s++) if (!sen_n[s]) ss_low = s;
          if (sclk && !prev_sclk) begin
            rises++;
            bits = {bits[30:0], mosi};
          end
          miso = (rises < 32) ? miso_word[31 - rises] : 1'b0;
        end else begin
          hi_run++;
          chk("idle_pins", {30'b0, sclk, mosi}, 32'd0);
          miso = 1'b0;
        end
        prev_sclk = sclk;
        if (done != 4'd0) begin
          rec_q.push_back('{done, low_cnt, ss_low, rises, bits, rd_data, busy});
          low_cnt = 0; ss_low = -1; rises = 0; bits = '0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(input int i, input int ss, input int len, input logic [31:0] data);
    req_ss[2*i +: 2]    = 2'(ss);
    req_len[6*i +: 6]   = 6'(len);
    req_data[32*i +: 32] = data;
    req_valid[i]        = 1'b1;
  endtask

  task automatic wait_rec(input int budget, output rec_t r, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk); #1;
      if (rec_q.size() > 0) begin
        r = rec_q.pop_front();
        ok = 1;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic check_rec(input rec_t r, input int req, input int slave, input int len, input int low,
                           input logic [31:0] bits, input logic [31:0] rd);
    chk("done_onehot", 32'(r.done), 32'(4'b0001 << req));
    chk("enable_low_cycles", 32'(r.low_cnt), 32'(low));
    chk("slave_select", 32'(r.ss_low), 32'(slave));
    chk("sclk_rises", 32'(r.rises), 32'(len));
    chk("mosi_bits", r.bits, bits);
    chk("rd_data", r.rd, rd);
    chk("busy_at_done", 32'(r.busy), 32'd1);
    $display("txn req=%0d ss=%0d len=%0d low=%0d bits=%08h rd=%08h", req, r.ss_low, r.rises, r.low_cnt, r.bits, r.rd);
  endtask

  function automatic int pick(input logic [3:0] p, input int from);
    for (int k = 0; k < 4; k++) if (p[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  logic [3:0]  pend;
  int          t_ss[4], t_len[4];
  logic [31:0] t_data[4];

  task automatic arm(input int i);
    t_ss[i]   = int'($urandom_range(3, 0));
    t_len[i]  = int'($urandom_range(32, 0));
    t_data[i] = $urandom;
    set_req(i, t_ss[i], t_len[i], t_data[i]);
    pend[i] = 1'b1;
  endtask

  initial begin : main
    vec_t tbl[6];
    rec_t r;
    bit   ok;
    int   order[6];
    int   ptr, expw, len;
    logic [31:0] eb, er;

    tbl[0] = '{0, 1, 16, 32'h0000A5C3, 32'h00000000, 1'b0, 1, 66, 32'h0000A5C3, 32'h00000000};
    tbl[1] = '{2, 2, 8, 32'h0000005A, 32'h3C000000, 1'b0, 2, 34, 32'h0000005A, 32'h0000003C};
    tbl[2] = '{1, 3, 0, 32'hDEADBEEF, 32'h12345678, 1'b0, -1, 0, 32'h00000000, 32'h00000000};
    tbl[3] = '{3, 0, 32, 32'hFFFFFFFF, 32'hAAAAAAAA, 1'b1, 0, 130, 32'hFFFFFFFF, 32'hAAAAAAAA};
    tbl[4] = '{1, 3, 1, 32'h00000001, 32'h80000000, 1'b0, 3, 6, 32'h00000001, 32'h00000001};
    tbl[5] = '{0, 2, 5, 32'hFFFFFF35, 32'hF8000000, 1'b1, 2, 22, 32'h00000015, 32'h0000001F};
    order = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1; req_valid = '0; req_ss = '0; req_len = '0; req_data = '0; miso_word = '0; pend = '0;
    repeat (3) @(negedge clk);
    chk("reset_sen_n", 32'(sen_n), 32'hF);
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_mosi", 32'(mosi), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // All four requesters held valid: strict rotation from pointer 0.
    for (int i = 0; i < 4; i++) set_req(i, i, 2, 32'(i));
    for (int n = 0; n < 6; n++) begin
      wait_rec(200, r, ok);
      if (ok) begin
        chk("rr_order", 32'(r.done), 32'(4'b0001 << order[n]));
        chk("rr_rises", 32'(r.rises), 32'd2);
        $display("txn rr n=%0d done=%b", n, r.done);
      end
      if (n == 5) req_valid = '0;
    end
    repeat (6) @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);

    // Directed table; request fields are scrambled once the grant has been taken.
    for (int t = 0; t < 6; t++) begin
      miso_word = tbl[t].miso;
      set_req(tbl[t].req, tbl[t].ss, tbl[t].len, tbl[t].data);
      ok = 0;
      for (int c = 0; c < 400 && !ok; c++) begin
        @(negedge clk); #1;
        if (rec_q.size() > 0) begin
          r = rec_q.pop_front();
          ok = 1;
          req_valid[tbl[t].req] = 1'b0;
        end else if (c == 3) begin
          req_data[32*tbl[t].req +: 32] = ~req_data[32*tbl[t].req +: 32];
          req_len[6*tbl[t].req +: 6]    = 6'd7;
          req_ss[2*tbl[t].req +: 2]     = ~req_ss[2*tbl[t].req +: 2];
          if (tbl[t].drop_mid) req_valid[tbl[t].req] = 1'b0;
        end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL table_timeout: entry %0d got no done, want one", t);
      end else begin
        check_rec(r, tbl[t].req, tbl[t].exp_slave, tbl[t].len, tbl[t].exp_low, tbl[t].exp_bits,
                  RB ? tbl[t].exp_rd_rb : 32'd0);
      end
    end

    // Back-to-back: pointer now 1, so req1 then req3; idle gap between them must be GAP_CYCLES.
    miso_word = '0;
    set_req(3, 0, 32, 32'hFFFFFFFF);
    set_req(1, 1, 3, 32'h5);
    wait_rec(400, r, ok);
    if (ok) begin req_valid[1] = 1'b0; check_rec(r, 1, 1, 3, DIV * 7, 32'h5, 32'd0); end
    wait_rec(400, r, ok);
    if (ok) begin req_valid[3] = 1'b0; check_rec(r, 3, 0, 32, DIV * 65, 32'hFFFFFFFF, 32'd0); end
    chk("gap_cycles", 32'(last_gap), 32'(GAP_CYCLES));

    // Asynchronous reset while sclk is high.
    set_req(2, 2, 24, 32'h00123456);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk); #1;
      if (sclk) ok = 1;
    end
    chk("reached_shift_hi", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_sen_n", 32'(sen_n), 32'hF);
    chk("async_rst_sclk", 32'(sclk), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_mosi", 32'(mosi), 32'd0);
    req_valid = '0;
    @(negedge clk); #1;
    rst = 1'b0;
    rec_q.delete();
    set_req(3, 3, 2, 32'h3);
    set_req(0, 1, 2, 32'h1);
    wait_rec(200, r, ok);
    if (ok) begin req_valid[0] = 1'b0; chk("post_rst_first", 32'(r.done), 32'h1); end
    wait_rec(200, r, ok);
    if (ok) begin req_valid[3] = 1'b0; chk("post_rst_second", 32'(r.done), 32'h8); end

    // Random traffic against a pointer-and-pending-set model; requests change only at done.
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    rec_q.delete();
    ptr = 0;
    pend = '0;
    for (int i = 0; i < 4; i++) if ($urandom_range(1, 0) == 1) arm(i);
    if (pend == 4'd0) arm(int'($urandom_range(3, 0)));
    miso_word = $urandom;
    expw = pick(pend, ptr);
    for (int n = 0; n < 40; n++) begin
      wait_rec(400, r, ok);
      if (!ok) break;
      len = t_len[expw];
      eb  = (len == 32) ? t_data[expw] : (t_data[expw] & ((32'd1 << len) - 32'd1));
      er  = (RB && len != 0) ? (miso_word >> (32 - len)) : 32'd0;
      check_rec(r, expw, (len == 0) ? -1 : t_ss[expw], len, (len == 0) ? 0 : DIV * (1 + 2 * len), eb, er);
      req_valid[expw] = 1'b0;
      pend[expw] = 1'b0;
      ptr = (expw + 1) % 4;
      for (int i = 0; i < 4; i++) if (!pend[i] && $urandom_range(1, 0) == 1) arm(i);
      if (pend == 4'd0) arm(int'($urandom_range(3, 0)));
      miso_word = $urandom;
      expw = pick(pend, ptr);
    end
    req_valid = '0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
